// File: rtl/seq_alu_pkg.sv
// Shared opcodes and FSM encoding for the sequential ALU.
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_mul_serial.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle.
module alu_mul_serial #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic               busy;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    // Bit 0 is folded in on the start edge so the product lands after WIDTH edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= CW'(1);
            acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier <= b >> 1;
        end else if (busy) begin
            if (cnt == LAST) begin
                busy <= 1'b0;
            end else begin
                acc    <= acc + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end
        end
    end

    assign done    = busy && (cnt == LAST);
    assign product = acc;

endmodule

// File: rtl/seq_alu.sv
// Handshaked N-bit ALU: single-cycle logic ops plus a serial multiply,
// with registered result, high word and status flags.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n
);

    localparam int M = WIDTH - 1;
    localparam logic [WIDTH-1:0] SH_LIM = WIDTH'(WIDTH);

    state_t             state;
    logic               accept;
    logic               start;
    logic               mul_done;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     dif;
    logic [WIDTH-1:0]   res;
    logic               c;
    logic               v;

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign start    = accept && (opcode == OP_MUL);
    assign sum      = {1'b0, a} + {1'b0, b};
    assign dif      = {1'b0, a} - {1'b0, b};

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (opcode)
            OP_ADD: begin
                res = sum[M:0];
                c   = sum[WIDTH];
                v   = (a[M] == b[M]) && (res[M] != a[M]);
            end
            OP_SUB: begin
                res = dif[M:0];
                c   = dif[WIDTH];
                v   = (a[M] != b[M]) && (res[M] != a[M]);
            end
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_AND: res = a & b;
            OP_SHL: res = (b >= SH_LIM) ? '0 : a << b;
            OP_SHR: res = (b >= SH_LIM) ? '0 : a >> b;
            default: ;
        endcase
    end

    alu_mul_serial #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            flag_v    <= 1'b0;
            flag_n    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && opcode == OP_MUL) begin
                        state <= S_BUSY;
                    end else if (accept) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= res;
                        result_hi <= '0;
                        flag_c    <= c;
                        flag_z    <= (res == '0);
                        flag_v    <= v;
                        flag_n    <= res[M];
                    end
                end
                S_BUSY: begin
                    if (mul_done) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= product[M:0];
                        result_hi <= product[2*WIDTH-1:WIDTH];
                        flag_c    <= |product[2*WIDTH-1:WIDTH];
                        flag_z    <= (product == '0);
                        flag_v    <= 1'b0;
                        flag_n    <= product[2*WIDTH-1];
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   opcode = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         flag_c, flag_z, flag_v, flag_n;

    int vectors = 0;
    int errs = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_v    (flag_v),
        .flag_n    (flag_n)
    );

    always #5 clk = ~clk;

    // Reference: {result_hi, result, c, z, v, n} from plain integer arithmetic.
    function automatic logic [2*W+3:0] model(input int op, input int x, input int y);
        int m, sx, sy, t, r, hi;
        bit c, z, v, n;
        m  = 1 << W;
        sx = (x >= m / 2) ? x - m : x;
        sy = (y >= m / 2) ? y - m : y;
        r = 0; hi = 0; c = 0; v = 0;
        case (op)
            0: begin
                t = x + y; r = t % m; c = (t >= m);
                t = sx + sy; v = (t > m / 2 - 1) || (t < -(m / 2));
            end
            1: r = x | y;
            2: begin
                r = (x - y + m) % m; c = (x < y);
                t = sx - sy; v = (t > m / 2 - 1) || (t < -(m / 2));
            end
            3: r = x ^ y;
            4: r = x & y;
            5: r = (y >= W) ? 0 : (x * (1 << y)) % m;
            6: r = (y >= W) ? 0 : x / (1 << y);
            default: begin
                t = x * y; r = t % m; hi = t / m; c = (hi != 0);
            end
        endcase
        z = (r == 0) && (hi == 0);
        n = (op == 7) ? (hi >= m / 2) : (r >= m / 2);
        return {W'(hi), W'(r), c, z, v, n};
    endfunction

    function automatic logic [2*W+3:0] obs();
        return {result_hi, result, flag_c, flag_z, flag_v, flag_n};
    endfunction

    task automatic issue(input int op, input int x, input int y);
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = 3'(op);
        a        = W'(x);
        b        = W'(y);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        opcode   = 3'($urandom);
    endtask

    task automatic wait_valid(output int lat, output bit rdy_seen);
        lat = 0;
        rdy_seen = 0;
        do begin
            @(negedge clk);
            lat++;
            if (in_ready) rdy_seen = 1;
        end while (!out_valid && lat < 50);
    endtask

    task automatic complete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({out_valid, obs()} !== '0) begin
            errs++;
            $display("FAIL reset_outputs got %h want 0", {out_valid, obs()});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errs++;
            $display("FAIL reset_release rdy/vld got %b want 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_directed();
        int ops[9] = '{0, 0, 2, 7, 5, 6, 1, 3, 4};
        int xs[9]  = '{15, 7, 3, 15, 3, 8, 10, 10, 10};
        int ys[9]  = '{1, 1, 5, 15, 2, 5, 6, 6, 6};
        int lat;
        bit rdy;
        logic [2*W+3:0] exp;
        for (int i = 0; i < 9; i++) begin
            issue(ops[i], xs[i], ys[i]);
            wait_valid(lat, rdy);
            exp = model(ops[i], xs[i], ys[i]);
            vectors++;
            if (lat != ((ops[i] == 7) ? W + 1 : 1) || rdy || in_ready) begin
                errs++;
                $display("FAIL dir_timing op%0d got lat=%0d rdy=%0b want lat=%0d rdy=0",
                         ops[i], lat, rdy | in_ready, (ops[i] == 7) ? W + 1 : 1);
            end
            vectors++;
            if (obs() !== exp) begin
                errs++;
                $display("FAIL dir_value op%0d a=%h b=%h got %h want %h",
                         ops[i], xs[i], ys[i], obs(), exp);
            end
            complete();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit rdy;
        logic [2*W+3:0] exp;
        issue(0, 5, 6);
        wait_valid(lat, rdy);
        exp = model(0, 5, 6);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            opcode   = 3'd2;
            a        = W'(1);
            b        = W'(2);
            @(negedge clk);
            vectors++;
            if ({out_valid, in_ready, obs()} !== {2'b10, exp}) begin
                errs++;
                $display("FAIL hold_cycle%0d got %h want %h", i,
                         {out_valid, in_ready, obs()}, {2'b10, exp});
            end
        end
        complete();
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errs++;
            $display("FAIL release vld/rdy got %b want 01", {out_valid, in_ready});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        exp = model(2, 1, 2);
        vectors++;
        if ({out_valid, obs()} !== {1'b1, exp}) begin
            errs++;
            $display("FAIL next_accept got %h want %h", {out_valid, obs()}, {1'b1, exp});
        end
        complete();
    endtask

    task automatic test_mul_abort();
        int lat;
        bit rdy;
        bit bad = 0;
        issue(3, 10, 6);
        wait_valid(lat, rdy);
        complete();
        issue(7, 15, 15);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, obs()} !== '0) begin
            errs++;
            $display("FAIL abort_outputs got %h want 0", {out_valid, obs()});
        end
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL abort_ready got %b want 1", in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1;
        end
        vectors++;
        if (bad) begin
            errs++;
            $display("FAIL abort_no_output got out_valid=1 want 0");
        end
    endtask

    task automatic test_random();
        int op, x, y, lat;
        bit rdy;
        logic [2*W+3:0] exp;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(7);
            x  = $urandom_range((1 << W) - 1);
            y  = $urandom_range((1 << W) - 1);
            issue(op, x, y);
            wait_valid(lat, rdy);
            exp = model(op, x, y);
            vectors++;
            if (lat != ((op == 7) ? W + 1 : 1) || rdy) begin
                errs++;
                $display("FAIL rnd_timing op%0d got lat=%0d want %0d", op, lat,
                         (op == 7) ? W + 1 : 1);
            end
            vectors++;
            if (obs() !== exp) begin
                errs++;
                $display("FAIL rnd_value op%0d a=%h b=%h got %h want %h",
                         op, x, y, obs(), exp);
            end
            repeat ($urandom_range(2)) begin
                @(negedge clk);
                vectors++;
                if ({out_valid, obs()} !== {1'b1, exp}) begin
                    errs++;
                    $display("FAIL rnd_hold op%0d got %h want %h", op,
                             {out_valid, obs()}, {1'b1, exp});
                end
            end
            complete();
        end
    endtask

    task automatic test_back_to_back();
        int op, x, y;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            op = $urandom_range(6);
            x  = $urandom_range((1 << W) - 1);
            y  = $urandom_range((1 << W) - 1);
            @(negedge clk);
            vectors++;
            if ({in_ready, out_valid} !== 2'b10) begin
                errs++;
                $display("FAIL b2b_ready%0d got %b want 10", i, {in_ready, out_valid});
            end
            in_valid = 1'b1;
            opcode   = 3'(op);
            a        = W'(x);
            b        = W'(y);
            @(negedge clk);
            in_valid = 1'b0;
            vectors++;
            if ({out_valid, in_ready, obs()} !== {2'b10, model(op, x, y)}) begin
                errs++;
                $display("FAIL b2b_value%0d got %h want %h", i,
                         {out_valid, in_ready, obs()}, {2'b10, model(op, x, y)});
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_mul_abort();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
